// File: rtl/sbox_share_sched.sv
// sbox_share_sched: serialises 32-bit words from two requesters through one shared AES S-box.
// Optional SBOX_SHARE_PIPE_EN adds a register stage on sbox_q (one extra drain cycle per word).
module sbox_share_sched #(
   parameter bit RR = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_word,
   input  logic        req0_encrypt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_word,
   input  logic        req1_encrypt,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_word,
   output logic [7:0]  sbox_a,
   output logic        sbox_encrypt,
   input  logic [7:0]  sbox_q
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state;
   logic [31:0] word;
   logic [1:0]  cnt;
   logic        last, g0, g1, acc, drn;
   // last holds the previous grant; requester 0 wins ties unless it was served last under RR
   always_comb begin
      g0 = req0_valid & (~req1_valid | ~RR | last);
      g1 = req1_valid & ~g0;
   end
   assign req0_ready = (state == IDLE) & g0;
   assign req1_ready = (state == IDLE) & g1;
   assign acc = req0_ready | req1_ready;
   assign sbox_a = (state == RUN && !drn) ? word[{cnt, 3'b000} +: 8] : 8'h00;
`ifdef SBOX_SHARE_PIPE_EN
   logic [7:0] q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= 8'h00;
      else q <= sbox_q;
`else
   assign drn = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         word         <= 32'h0;
         cnt          <= 2'd0;
         last         <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_word     <= 32'h0;
         sbox_encrypt <= 1'b0;
`ifdef SBOX_SHARE_PIPE_EN
         drn          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (acc) begin
               word         <= g0 ? req0_word : req1_word;
               sbox_encrypt <= g0 ? req0_encrypt : req1_encrypt;
               rsp_id       <= g1;
               last         <= g1;
               cnt          <= 2'd0;
`ifdef SBOX_SHARE_PIPE_EN
               drn          <= 1'b0;
`endif
               state        <= RUN;
            end
            RUN: begin
`ifdef SBOX_SHARE_PIPE_EN
               // q lags sbox_a by one edge, so byte cnt-1 lands while byte cnt is presented
               if (drn) begin
                  rsp_word[31:24] <= q;
                  rsp_valid       <= 1'b1;
                  state           <= DONE;
               end else begin
                  if (cnt != 2'd0) rsp_word[{cnt - 2'd1, 3'b000} +: 8] <= q;
                  drn <= (cnt == 2'd3);
                  cnt <= cnt + 2'd1;
               end
`else
               rsp_word[{cnt, 3'b000} +: 8] <= sbox_q;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
`endif
            end
            DONE: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
